// File: rtl/vliw_bus_pkg.sv
// Shared constants and the read-slot record used by the memory bus responder.
package vliw_bus_pkg;
  localparam int BUS_DATA_WIDTH = 64;
  localparam int WORD_OFFSET_BITS = 3;
  localparam logic [BUS_DATA_WIDTH-1:0] ERR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic                      valid;
    logic [BUS_DATA_WIDTH-1:0] data;
  } read_slot_t;
endpackage

// File: rtl/bus_memory_responder_if.sv
// Core-side memory bus: address/write-data/write-enable toward memory, read data and valid back.
interface bus_memory_responder_if #(
  parameter int PAS = 56
);
  import vliw_bus_pkg::*;

  logic [PAS-1:0]            addressBus;
  logic [BUS_DATA_WIDTH-1:0] dataOut;
  logic                      enableWrite;
  logic [BUS_DATA_WIDTH-1:0] dataIn;
  logic                      dataValid;

  modport master (output addressBus, dataOut, enableWrite, input dataIn, dataValid);
  modport slave  (input addressBus, dataOut, enableWrite, output dataIn, dataValid);
endinterface

// File: rtl/bus_read_delay_line.sv
// Fixed-depth shift register of read slots; a synchronous clear invalidates every slot in flight.
module bus_read_delay_line
  import vliw_bus_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  read_slot_t slot_in,
  output read_slot_t slot_out
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst;
      assign slot_out = slot_in;
    end else begin : g_pipe
      read_slot_t stage [LATENCY];

      // Only the valid bits are cleared; stale data behind an invalid slot is harmless.
      always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
          if (rst) begin
            stage[i].valid <= 1'b0;
          end else if (i == 0) begin
            stage[i].valid <= slot_in.valid;
          end else begin
            stage[i].valid <= stage[i-1].valid;
          end
          stage[i].data <= (i == 0) ? slot_in.data : stage[i-1].data;
        end
      end

      assign slot_out = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/bus_memory_responder.sv
// Word-addressed 64-bit memory target for the core bus with fixed read latency,
// window decode with sticky error capture, a preload port and saturating access counters.
module bus_memory_responder
  import vliw_bus_pkg::*;
#(
  parameter int                                PHYSICAL_ADDRESS_SIZE = 56,
  parameter int                                DEPTH                 = 4096,
  parameter logic [PHYSICAL_ADDRESS_SIZE-1:0]  BASE_ADDR             = '0,
  parameter int                                READ_LATENCY          = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  bus_memory_responder_if.slave             bus,
  input  logic                              loadEnable,
  input  logic [$clog2(DEPTH)-1:0]          loadIndex,
  input  logic [BUS_DATA_WIDTH-1:0]         loadData,
  output logic                              writeDropped,
  output logic                              busError,
  output logic [PHYSICAL_ADDRESS_SIZE-1:0]  errorAddress,
  output logic [31:0]                       readCount,
  output logic [31:0]                       writeCount
);

  localparam int PAS   = PHYSICAL_ADDRESS_SIZE;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PAS-1:0] WINDOW_BYTES = PAS'(DEPTH) << WORD_OFFSET_BITS;

  logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

  logic [PAS:0]     diff;
  logic             in_window;
  logic [IDX_W-1:0] index;
  logic             rd_req;
  logic             wr_hit;
  logic             wr_commit;
  logic             err_hit;
  read_slot_t       rd_slot_p0;
  read_slot_t       rd_slot_pn;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stage p0: decode and sample memory combinationally; the edge captures pre-write data.
  always_comb begin
    diff       = {1'b0, bus.addressBus} - {1'b0, BASE_ADDR};
    in_window  = !diff[PAS] && (diff[PAS-1:0] < WINDOW_BYTES);
    index      = diff[WORD_OFFSET_BITS +: IDX_W];
    rd_req     = !rst && !bus.enableWrite;
    wr_hit     = !rst && bus.enableWrite && in_window;
    wr_commit  = wr_hit && !loadEnable;
    err_hit    = !rst && !in_window;
    rd_slot_p0.valid = rd_req;
    rd_slot_p0.data  = in_window ? mem[index] : ERR_PATTERN;
  end

  // Preload has priority over a colliding bus write and works regardless of rst.
  always_ff @(posedge clk) begin
    if (loadEnable) begin
      mem[loadIndex] <= loadData;
    end else if (wr_commit) begin
      mem[index] <= bus.dataOut;
    end
  end

  bus_read_delay_line #(
    .LATENCY (READ_LATENCY - 1)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .slot_in  (rd_slot_p0),
    .slot_out (rd_slot_pn)
  );

  // Stage pN: output register; dataIn holds whenever no valid slot exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dataIn    <= '0;
      bus.dataValid <= 1'b0;
      writeDropped  <= 1'b0;
      busError      <= 1'b0;
      errorAddress  <= '0;
      readCount     <= '0;
      writeCount    <= '0;
    end else begin
      bus.dataValid <= rd_slot_pn.valid;
      if (rd_slot_pn.valid) begin
        bus.dataIn <= rd_slot_pn.data;
      end
      writeDropped <= wr_hit && loadEnable;
      if (err_hit && !busError) begin
        busError     <= 1'b1;
        errorAddress <= bus.addressBus;
      end
      if (rd_req && in_window) begin
        readCount <= sat_inc(readCount);
      end
      if (wr_commit) begin
        writeCount <= sat_inc(writeCount);
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Drives two responders (read latency 1 and 3) with identical traffic and checks both against a reference model.
module tb_bus_memory_responder;

  localparam logic [63:0] ERR_WORD  = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [55:0] WIN_BYTES = 56'h8000;

  typedef struct packed {
    int          due;
    logic [63:0] data;
  } pend_t;

  logic        clk;
  logic        rst;
  logic [55:0] addr;
  logic [63:0] wdata;
  logic        we;
  logic        le;
  logic [11:0] li;
  logic [63:0] ld;

  logic        wd1, be1, wd3, be3;
  logic [55:0] ea1, ea3;
  logic [31:0] rc1, wc1, rc3, wc3;

  bus_memory_responder_if #(.PAS(56)) bus1 ();
  bus_memory_responder_if #(.PAS(56)) bus3 ();

  assign bus1.addressBus  = addr;
  assign bus1.dataOut     = wdata;
  assign bus1.enableWrite = we;
  assign bus3.addressBus  = addr;
  assign bus3.dataOut     = wdata;
  assign bus3.enableWrite = we;

  bus_memory_responder #(
    .PHYSICAL_ADDRESS_SIZE (56), .DEPTH (4096), .BASE_ADDR (56'h0), .READ_LATENCY (1)
  ) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1),
    .loadEnable (le), .loadIndex (li), .loadData (ld),
    .writeDropped (wd1), .busError (be1), .errorAddress (ea1),
    .readCount (rc1), .writeCount (wc1)
  );

  bus_memory_responder #(
    .PHYSICAL_ADDRESS_SIZE (56), .DEPTH (4096), .BASE_ADDR (56'h0), .READ_LATENCY (3)
  ) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3),
    .loadEnable (le), .loadIndex (li), .loadData (ld),
    .writeDropped (wd3), .busError (be3), .errorAddress (ea3),
    .readCount (rc3), .writeCount (wc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mem_m [4096];
  pend_t       q1[$];
  pend_t       q3[$];
  logic [63:0] e_di1, e_di3;
  logic        e_dv1, e_dv3, e_wd, e_be;
  logic [55:0] e_ea;
  logic [31:0] e_rc, e_wc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dataIn_L1",       bus1.dataIn,         e_di1);
    chk("dataValid_L1",    64'(bus1.dataValid), 64'(e_dv1));
    chk("dataIn_L3",       bus3.dataIn,         e_di3);
    chk("dataValid_L3",    64'(bus3.dataValid), 64'(e_dv3));
    chk("writeDropped",    64'(wd1),            64'(e_wd));
    chk("writeDropped_L3", 64'(wd3),            64'(e_wd));
    chk("busError",        64'(be1),            64'(e_be));
    chk("busError_L3",     64'(be3),            64'(e_be));
    chk("errorAddress",    64'(ea1),            64'(e_ea));
    chk("errorAddress_L3", 64'(ea3),            64'(e_ea));
    chk("readCount",       64'(rc1),            64'(e_rc));
    chk("readCount_L3",    64'(rc3),            64'(e_rc));
    chk("writeCount",      64'(wc1),            64'(e_wc));
    chk("writeCount_L3",   64'(wc3),            64'(e_wc));
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input logic r, input logic w, input logic [55:0] a, input logic [63:0] d,
                       input logic l, input logic [11:0] lidx, input logic [63:0] ldat);
    logic        inwin;
    logic [11:0] idx;
    logic [63:0] rdat;
    rst = r; we = w; addr = a; wdata = d; le = l; li = lidx; ld = ldat;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      q1.delete(); q3.delete();
      e_di1 = '0; e_dv1 = 1'b0; e_di3 = '0; e_dv3 = 1'b0;
      e_wd = 1'b0; e_be = 1'b0; e_ea = '0; e_rc = '0; e_wc = '0;
      if (l) mem_m[lidx] = ldat;
    end else begin
      inwin = (a < WIN_BYTES);
      idx   = a[14:3];
      e_wd  = 1'b0;
      if (!w) begin
        rdat = inwin ? mem_m[idx] : ERR_WORD;
        q1.push_back('{due: cyc,     data: rdat});
        q3.push_back('{due: cyc + 2, data: rdat});
        if (inwin && e_rc != 32'hFFFF_FFFF) e_rc++;
      end else if (inwin) begin
        if (l) e_wd = 1'b1;
        else begin
          mem_m[idx] = d;
          if (e_wc != 32'hFFFF_FFFF) e_wc++;
        end
      end
      if (l) mem_m[lidx] = ldat;
      if (!inwin && !e_be) begin
        e_be = 1'b1;
        e_ea = a;
      end
      e_dv1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e_dv1 = 1'b1; e_di1 = q1[0].data; void'(q1.pop_front());
      end
      e_dv3 = 1'b0;
      if (q3.size() > 0 && q3[0].due == cyc) begin
        e_dv3 = 1'b1; e_di3 = q3[0].data; void'(q3.pop_front());
      end
    end
    check_all();
  endtask

  initial begin
    logic [63:0] saved;
    logic [63:0] rnd;
    logic        rw, rl, rr;
    logic [55:0] ra;

    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; le = 1'b0; li = '0; ld = '0;

    // Preload the whole image while held in reset, then two plain reset cycles.
    for (int i = 0; i < 4096; i++) begin
      rnd = {$urandom(), $urandom()};
      if (i == 5) rnd = 64'h5555_0000_5555_0005;
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 12'(i), rnd);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("reset_dataIn", bus1.dataIn, 64'h0);
    chk("reset_busError", 64'(be1), 64'h0);

    cycle(1'b0, 1'b0, 56'h28, '0, 1'b0, '0, '0);
    chk("preload_kept", bus1.dataIn, 64'h5555_0000_5555_0005);

    // Write, read back, and aligned-down read.
    cycle(1'b0, 1'b1, 56'h40, 64'h1122334455667788, 1'b0, '0, '0);
    chk("t2_wcount", 64'(wc1), 64'd1);
    cycle(1'b0, 1'b0, 56'h40, '0, 1'b0, '0, '0);
    chk("t2_read", bus1.dataIn, 64'h1122334455667788);
    cycle(1'b0, 1'b0, 56'h47, '0, 1'b0, '0, '0);
    chk("t2_align", bus1.dataIn, 64'h1122334455667788);

    // Streamed reads through the latency-3 pipe.
    cycle(1'b0, 1'b0, 56'h100, '0, 1'b1, 12'd0, 64'hAAAA_0000_0000_000A);
    cycle(1'b0, 1'b0, 56'h100, '0, 1'b1, 12'd1, 64'hBBBB_0000_0000_000B);
    cycle(1'b0, 1'b0, 56'h100, '0, 1'b1, 12'd2, 64'hCCCC_0000_0000_000C);
    cycle(1'b0, 1'b0, 56'h0,  '0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, 56'h8,  '0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, 56'h10, '0, 1'b0, '0, '0);
    chk("t3_first", bus3.dataIn, 64'hAAAA_0000_0000_000A);
    cycle(1'b0, 1'b0, 56'h100, '0, 1'b0, '0, '0);
    chk("t3_second", bus3.dataIn, 64'hBBBB_0000_0000_000B);
    cycle(1'b0, 1'b0, 56'h100, '0, 1'b0, '0, '0);
    chk("t3_third", bus3.dataIn, 64'hCCCC_0000_0000_000C);

    // Out-of-window read then write.
    saved = mem_m[12'h200];
    cycle(1'b0, 1'b0, 56'h8000, '0, 1'b0, '0, '0);
    chk("t4_err_data", bus1.dataIn, ERR_WORD);
    chk("t4_err_addr", 64'(ea1), 64'h8000);
    cycle(1'b0, 1'b1, 56'h9000, 64'h0123_4567_89AB_CDEF, 1'b0, '0, '0);
    chk("t4_err_addr_kept", 64'(ea1), 64'h8000);
    cycle(1'b0, 1'b0, 56'h1000, '0, 1'b0, '0, '0);
    chk("t4_mem_unchanged", bus1.dataIn, saved);

    // Preload collides with a bus write.
    cycle(1'b0, 1'b1, 56'h10, 64'hBB, 1'b1, 12'd2, 64'hAA);
    chk("t5_dropped", 64'(wd1), 64'd1);
    chk("t5_wcount", 64'(wc1), 64'd1);
    cycle(1'b0, 1'b0, 56'h10, '0, 1'b0, '0, '0);
    chk("t5_load_wins", bus1.dataIn, 64'hAA);

    // Reset with reads in flight.
    cycle(1'b0, 1'b0, 56'h0, '0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, 56'h8, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 56'h0, '0, 1'b0, '0, '0);
    chk("t6_rst_dataIn", bus3.dataIn, 64'h0);
    cycle(1'b0, 1'b0, 56'h0, '0, 1'b0, '0, '0);
    chk("t6_no_stale_a", 64'(bus3.dataValid), 64'd0);
    cycle(1'b0, 1'b0, 56'h0, '0, 1'b0, '0, '0);
    chk("t6_no_stale_b", 64'(bus3.dataValid), 64'd0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      rw = $urandom_range(0, 1) == 1;
      rl = $urandom_range(0, 3) == 0;
      rr = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 7) == 0) ra = 56'h8000 + 56'($urandom_range(0, 32'hFFFF));
      else                           ra = 56'($urandom_range(0, 32'h7FFF));
      cycle(rr, rw, ra, {$urandom(), $urandom()}, rl, 12'($urandom_range(0, 4095)),
            {$urandom(), $urandom()});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
